// File: rtl/nmea_gga_field_extractor.sv
// nmea_gga_field_extractor: finds GP/GN GGA sentences in a UART byte stream,
// verifies the XOR checksum and emits the lat then lon field as converter records.
//   clk, rst        : clock, async active-high reset
//   rx_data/valid   : received byte and its one-cycle strobe (no backpressure)
//   out_valid       : one-cycle record strobe; out_is_lon/out_ascii/out_len/out_sign
//                     hold their last values between strobes
//   sent_ok, err_cksum, err_format, overrun : one status pulse per sentence
module nmea_gga_field_extractor #(
    parameter int MAX_FIELD = 16,
    parameter int EMIT_GAP  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   out_valid,
    output logic                   out_is_lon,
    output logic [8*MAX_FIELD-1:0] out_ascii,
    output logic [7:0]             out_len,
    output logic                   out_sign,
    output logic                   sent_ok,
    output logic                   err_cksum,
    output logic                   err_format,
    output logic                   overrun
);

    localparam int AW = 8 * MAX_FIELD;
    localparam int GW = (EMIT_GAP < 2) ? 1 : $clog2(EMIT_GAP);
    localparam logic [7:0] MAXL = 8'(MAX_FIELD);

    localparam logic [2:0] P_IDLE  = 3'd0;
    localparam logic [2:0] P_HDR   = 3'd1;
    localparam logic [2:0] P_FIELD = 3'd2;
    localparam logic [2:0] P_CK1   = 3'd3;
    localparam logic [2:0] P_CK2   = 3'd4;
    localparam logic [2:0] P_CHECK = 3'd5;

    localparam logic [1:0] E_IDLE = 2'd0;
    localparam logic [1:0] E_LAT  = 2'd1;
    localparam logic [1:0] E_GAP  = 2'd2;
    localparam logic [1:0] E_LON  = 2'd3;

    logic [2:0]    p_state;
    logic [2:0]    hpos;
    logic [2:0]    fidx;
    logic [7:0]    f_cnt;
    logic [7:0]    f_first;
    logic [7:0]    ck_acc;
    logic [3:0]    ck_hi;
    logic [3:0]    ck_lo;
    logic [AW-1:0] lat_buf;
    logic [AW-1:0] lon_buf;
    logic [7:0]    lat_len;
    logic [7:0]    lon_len;
    logic          lat_sign;
    logic          lon_sign;
    logic          fix_ok;

    logic [1:0]    e_state;
    logic [GW-1:0] gap_cnt;
    logic [AW-1:0] hold_ascii;
    logic [7:0]    hold_len;
    logic          hold_sign;

    logic [4:0] hex;
    logic       ns_ok;
    logic       ew_ok;
    logic       busy;
    logic       ck_match;
    logic       fix_good;
    logic       start;

    // {valid, nibble}; both letter cases are accepted
    function automatic logic [4:0] hex_dec(input logic [7:0] c);
        if (c >= "0" && c <= "9") return {1'b1, 4'(c - 8'h30)};
        if (c >= "A" && c <= "F") return {1'b1, 4'(c - 8'h37)};
        if (c >= "a" && c <= "f") return {1'b1, 4'(c - 8'h57)};
        return 5'd0;
    endfunction

    function automatic logic hdr_ok(input logic [2:0] pos, input logic [7:0] c);
        case (pos)
            3'd0:    return c == "G";
            3'd1:    return c == "P" || c == "N";
            3'd2:    return c == "G";
            3'd3:    return c == "G";
            3'd4:    return c == "A";
            default: return 1'b0;
        endcase
    endfunction

    assign hex      = hex_dec(rx_data);
    assign ns_ok    = f_cnt == 8'd1 && (f_first == "N" || f_first == "S");
    assign ew_ok    = f_cnt == 8'd1 && (f_first == "E" || f_first == "W");
    assign busy     = e_state != E_IDLE;
    assign ck_match = ck_acc == {ck_hi, ck_lo};
    assign fix_good = lat_len != 8'd0 && lon_len != 8'd0 && fix_ok;
    assign start    = p_state == P_CHECK && ck_match && fix_good && !busy;

    // Parser: one transition per accepted byte, plus the CHECK cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_state    <= P_IDLE;
            hpos       <= '0;
            fidx       <= '0;
            f_cnt      <= '0;
            f_first    <= '0;
            ck_acc     <= '0;
            ck_hi      <= '0;
            ck_lo      <= '0;
            lat_buf    <= '0;
            lon_buf    <= '0;
            lat_len    <= '0;
            lon_len    <= '0;
            lat_sign   <= 1'b0;
            lon_sign   <= 1'b0;
            fix_ok     <= 1'b0;
            sent_ok    <= 1'b0;
            err_cksum  <= 1'b0;
            err_format <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            sent_ok    <= 1'b0;
            err_cksum  <= 1'b0;
            err_format <= 1'b0;
            overrun    <= 1'b0;
            if (p_state == P_CHECK) begin
                p_state <= P_IDLE;
                if (!ck_match)     err_cksum  <= 1'b1;
                else if (!fix_good) err_format <= 1'b1;
                else if (busy)     overrun    <= 1'b1;
                else               sent_ok    <= 1'b1;
            end
            if (rx_valid) begin
                if (rx_data == "$") begin
                    p_state  <= P_HDR;
                    hpos     <= '0;
                    fidx     <= '0;
                    f_cnt    <= '0;
                    f_first  <= '0;
                    ck_acc   <= '0;
                    lat_buf  <= '0;
                    lon_buf  <= '0;
                    lat_len  <= '0;
                    lon_len  <= '0;
                    lat_sign <= 1'b0;
                    lon_sign <= 1'b0;
                    fix_ok   <= 1'b0;
                end else begin
                    case (p_state)
                        P_HDR: begin
                            ck_acc <= ck_acc ^ rx_data;
                            if (hpos == 3'd5) begin
                                if (rx_data == ",") begin
                                    p_state <= P_FIELD;
                                    fidx    <= 3'd1;
                                    f_cnt   <= '0;
                                end else begin
                                    err_format <= 1'b1;
                                    p_state    <= P_IDLE;
                                end
                            end else if (hdr_ok(hpos, rx_data)) begin
                                hpos <= hpos + 3'd1;
                            end else begin
                                // other sentence types are ordinary traffic
                                p_state <= P_IDLE;
                            end
                        end
                        P_FIELD: begin
                            if (rx_data == "," || rx_data == "*") begin
                                f_cnt   <= '0;
                                p_state <= (rx_data == "*") ? P_CK1 : P_FIELD;
                                if (rx_data == ",") ck_acc <= ck_acc ^ rx_data;
                                if (fidx != 3'd7) fidx <= fidx + 3'd1;
                                case (fidx)
                                    3'd3: begin
                                        lat_sign <= f_first == "S";
                                        if (!ns_ok) begin
                                            err_format <= 1'b1;
                                            p_state    <= P_IDLE;
                                        end
                                    end
                                    3'd5: begin
                                        lon_sign <= f_first == "W";
                                        if (!ew_ok) begin
                                            err_format <= 1'b1;
                                            p_state    <= P_IDLE;
                                        end
                                    end
                                    3'd6: fix_ok <= f_cnt != 8'd0 &&
                                        !(f_cnt == 8'd1 && f_first == "0");
                                    default: ;
                                endcase
                            end else begin
                                ck_acc <= ck_acc ^ rx_data;
                                if (f_cnt == 8'd0) f_first <= rx_data;
                                if (f_cnt != 8'hFF) f_cnt <= f_cnt + 8'd1;
                                if (fidx == 3'd2) begin
                                    if (lat_len == MAXL) begin
                                        err_format <= 1'b1;
                                        p_state    <= P_IDLE;
                                    end else begin
                                        lat_buf[AW-8-8*int'(lat_len) +: 8] <= rx_data;
                                        lat_len <= lat_len + 8'd1;
                                    end
                                end
                                if (fidx == 3'd4) begin
                                    if (lon_len == MAXL) begin
                                        err_format <= 1'b1;
                                        p_state    <= P_IDLE;
                                    end else begin
                                        lon_buf[AW-8-8*int'(lon_len) +: 8] <= rx_data;
                                        lon_len <= lon_len + 8'd1;
                                    end
                                end
                            end
                        end
                        P_CK1: begin
                            if (hex[4]) begin
                                ck_hi   <= hex[3:0];
                                p_state <= P_CK2;
                            end else begin
                                err_format <= 1'b1;
                                p_state    <= P_IDLE;
                            end
                        end
                        P_CK2: begin
                            if (hex[4]) begin
                                ck_lo   <= hex[3:0];
                                p_state <= P_CHECK;
                            end else begin
                                err_format <= 1'b1;
                                p_state    <= P_IDLE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Emitter: lat record is loaded straight from the working buffers at the
    // CHECK edge; lon is parked in the hold registers until the gap expires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_state    <= E_IDLE;
            gap_cnt    <= '0;
            out_is_lon <= 1'b0;
            out_ascii  <= '0;
            out_len    <= '0;
            out_sign   <= 1'b0;
            hold_ascii <= '0;
            hold_len   <= '0;
            hold_sign  <= 1'b0;
        end else begin
            case (e_state)
                E_IDLE: begin
                    if (start) begin
                        out_is_lon <= 1'b0;
                        out_ascii  <= lat_buf;
                        out_len    <= lat_len;
                        out_sign   <= lat_sign;
                        hold_ascii <= lon_buf;
                        hold_len   <= lon_len;
                        hold_sign  <= lon_sign;
                        e_state    <= E_LAT;
                    end
                end
                E_LAT: begin
                    gap_cnt <= GW'(EMIT_GAP - 1);
                    e_state <= E_GAP;
                end
                E_GAP: begin
                    if (gap_cnt == '0) begin
                        out_is_lon <= 1'b1;
                        out_ascii  <= hold_ascii;
                        out_len    <= hold_len;
                        out_sign   <= hold_sign;
                        e_state    <= E_LON;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: e_state <= E_IDLE;
            endcase
        end
    end

    assign out_valid = e_state == E_LAT || e_state == E_LON;

endmodule
